tea_asmd_enc: RTL

TEA_ASMD_ENC -- requirements
Module: tea_asmd_enc

---
 rtl/tea_asmd_enc_if.sv | 20 ++
 rtl/tea_asmd_enc.sv | 112 +++++++++++
 2 files changed

// File: rtl/tea_asmd_enc_if.sv
// Handshake bundle for the TEA encryptor: request side drives
// enable/start/plaintext/key, the core returns ciphertext and ready.
interface tea_asmd_enc_if;
    logic         ena;
    logic         start;
    logic [63:0]  data;
    logic [127:0] key;
    logic [63:0]  res;
    logic         rdy;

    modport master (
        output ena, start, data, key,
        input  res, rdy
    );

    modport slave (
        input  ena, start, data, key,
        output res, rdy
    );
endinterface

// File: rtl/tea_asmd_enc.sv
// Iterative TEA encryptor: one full TEA cycle (both half-rounds)
// per enabled clock, ROUNDS cycles per block.
module tea_asmd_enc #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input logic          clk,
    input logic          rst,
    tea_asmd_enc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    state_t      state, state_n;
    logic [31:0] v0, v1, v0_n, v1_n;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] k0_n, k1_n, k2_n, k3_n;
    logic [31:0] sum, sum_n;
    logic [7:0]  cnt, cnt_n;
    logic [63:0] res, res_n;
    logic        rdy, rdy_n;

    logic [31:0] sum_r, v0_r, v1_r;

    // v1 half-round uses the freshly updated v0
    always_comb begin
        sum_r = sum + DELTA;
        v0_r  = v0 + (((v1 << 4) + k0) ^ (v1 + sum_r)
                    ^ ((v1 >> 5) + k1));
        v1_r  = v1 + (((v0_r << 4) + k2) ^ (v0_r + sum_r)
                    ^ ((v0_r >> 5) + k3));
    end

    always_comb begin
        state_n = state;
        v0_n    = v0;
        v1_n    = v1;
        k0_n    = k0;
        k1_n    = k1;
        k2_n    = k2;
        k3_n    = k3;
        sum_n   = sum;
        cnt_n   = cnt;
        res_n   = res;
        rdy_n   = rdy;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    {v0_n, v1_n} = bus.data;
                    {k0_n, k1_n, k2_n, k3_n} = bus.key;
                    sum_n   = '0;
                    cnt_n   = '0;
                    rdy_n   = 1'b0;
                    state_n = CALC;
                end
            end
            CALC: begin
                v0_n  = v0_r;
                v1_n  = v1_r;
                sum_n = sum_r;
                cnt_n = cnt + 8'd1;
                if (cnt == LAST) begin
                    res_n   = {v0_r, v1_r};
                    rdy_n   = 1'b1;
                    state_n = DONE;
                end
            end
            default: begin
                rdy_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            v0    <= '0;
            v1    <= '0;
            k0    <= '0;
            k1    <= '0;
            k2    <= '0;
            k3    <= '0;
            sum   <= '0;
            cnt   <= '0;
            res   <= '0;
            rdy   <= 1'b0;
        end else if (bus.ena) begin
            state <= state_n;
            v0    <= v0_n;
            v1    <= v1_n;
            k0    <= k0_n;
            k1    <= k1_n;
            k2    <= k2_n;
            k3    <= k3_n;
            sum   <= sum_n;
            cnt   <= cnt_n;
            res   <= res_n;
            rdy   <= rdy_n;
        end
    end

    assign bus.res = res;
    assign bus.rdy = rdy;

endmodule
